fp_addsub_rnd: RTL and testbench

- Parametrised, self-contained IEEE-754-style floating-point add/subtract unit with a multi-cycle FSM datapath and four selectable rounding modes.
- Successor to the single-precision adder controller: no external adder callee, generic exponent/mantissa widths, full valid/ready handshakes on both sides, and special-operand handling.
- Sits between the FPU operand dispatcher and the result writeback/exception logger.

---
 rtl/fp_addsub_rnd.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_fp_addsub_rnd.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_rnd.sv
// fp_addsub_rnd: parametrised floating-point add/subtract with four rounding
// modes. The operation runs through a fixed six-state sequence
// (IDLE, ALIGN, ADD, NORM, ROUND, DONE).
// It has valid/ready handshakes on the operand side and the result side.
module fp_addsub_rnd #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] Datain1,
  input  logic [W-1:0] Datain2,
  input  logic         Mode,
  input  logic [1:0]   Rnd,
  input  logic         Data_valid,
  output logic         Data_ready,
  output logic [W-1:0] Dataout,
  output logic [3:0]   Exc,
  output logic         Dataout_valid,
  input  logic         Dataout_ready,
  output logic         Busy
);

  // Significand field: {carry, hidden, frac, G, R, S}
  localparam int SW  = MAN_W + 5;
  localparam int EW  = EXP_W + 1;
  localparam int LZW = $clog2(SW) + 1;
  localparam int CW  = (EW > LZW) ? EW : LZW;
  localparam logic [EW-1:0]    EW_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]    EMAX    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [LZW-1:0]   LZ_ONE  = {{(LZW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] E_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] E_ZERO  = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] F_ZERO  = {MAN_W{1'b0}};
  localparam logic [W-1:0]     QNAN    = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t         state_r;
  logic [W-1:0]   a_r, b_r;
  logic           mode_r;
  logic [1:0]     rnd_r;
  logic           sign1_r, same_sign_r;
  logic [EW-1:0]  exp1_r;
  logic [SW-1:0]  sig1_r, sig2_r, sum_r;
  logic           spec_r, spec_inv_r;
  logic [W-1:0]   spec_res_r;
  logic [W-1:0]   res_r, dout_r;
  logic [3:0]     exc_r, exc_out_r;
  logic           dvalid_r, ready_r, busy_r;

  // Leading-zero count from the hidden-bit position downwards
  function automatic logic [LZW-1:0] lzc_f(input logic [SW-2:0] v);
    logic [LZW-1:0] cnt;
    logic           found;
    cnt   = {LZW{1'b0}};
    found = 1'b0;
    for (int i = SW - 2; i >= 0; i--) begin
      if (!found && !v[i]) cnt = cnt + LZ_ONE;
      else found = 1'b1;
    end
    return cnt;
  endfunction

  // ALIGN: unpack, order by magnitude, shift Op2 right, detect special operands
  logic               sa_s, sb_s, swap_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s;
  logic [EXP_W-1:0]   ea_s, eb_s;
  logic [MAN_W-1:0]   fa_s, fb_s;
  logic [EW-1:0]      effa_s, effb_s, e1_s, e2_s, dist_s;
  logic [SW-1:0]      siga_s, sigb_s, sig1_s, sig2pre_s, shr_s, lost_s, sig2_s;
  logic               s1_s, spec_s, spec_inv_s;
  logic [W-1:0]       spec_res_s;
  always_comb begin
    sa_s    = a_r[W-1];
    sb_s    = b_r[W-1] ^ mode_r;
    ea_s    = a_r[W-2:MAN_W];
    eb_s    = b_r[W-2:MAN_W];
    fa_s    = a_r[MAN_W-1:0];
    fb_s    = b_r[MAN_W-1:0];
    a_nan_s = (ea_s == E_ONES) && (fa_s != F_ZERO);
    b_nan_s = (eb_s == E_ONES) && (fb_s != F_ZERO);
    a_inf_s = (ea_s == E_ONES) && (fa_s == F_ZERO);
    b_inf_s = (eb_s == E_ONES) && (fb_s == F_ZERO);
    effa_s  = (ea_s == E_ZERO) ? EW_ONE : {1'b0, ea_s};
    effb_s  = (eb_s == E_ZERO) ? EW_ONE : {1'b0, eb_s};
    siga_s  = {1'b0, (ea_s != E_ZERO), fa_s, 3'b000};
    sigb_s  = {1'b0, (eb_s != E_ZERO), fb_s, 3'b000};
    swap_s  = (b_r[W-2:0] > a_r[W-2:0]);
    s1_s      = swap_s ? sb_s : sa_s;
    e1_s      = swap_s ? effb_s : effa_s;
    e2_s      = swap_s ? effa_s : effb_s;
    sig1_s    = swap_s ? sigb_s : siga_s;
    sig2pre_s = swap_s ? siga_s : sigb_s;
    dist_s    = e1_s - e2_s;
    shr_s     = {SW{1'b0}};
    lost_s    = {SW{1'b0}};
    if (int'(dist_s) >= MAN_W + 3) begin
      sig2_s = {{(SW-1){1'b0}}, |sig2pre_s};
    end else begin
      shr_s  = sig2pre_s >> dist_s;
      lost_s = sig2pre_s << (SW - int'(dist_s));
      sig2_s = {shr_s[SW-1:1], shr_s[0] | (|lost_s)};
    end
    spec_s     = 1'b0;
    spec_inv_s = 1'b0;
    spec_res_s = {W{1'b0}};
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
      spec_s     = 1'b1;
      spec_inv_s = 1'b1;
      spec_res_s = QNAN;
    end else if (a_inf_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sa_s, E_ONES, F_ZERO};
    end else if (b_inf_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sb_s, E_ONES, F_ZERO};
    end else begin
      spec_s = 1'b0;
    end
  end

  // NORM: fold a carry right, or shift left without dropping below exponent 1
  logic [LZW-1:0] lz_s;
  logic [EW-1:0]  lim_s, nexp_s;
  logic [CW-1:0]  shamt_s;
  logic [SW-1:0]  nsum_s;
  always_comb begin
    lz_s    = lzc_f(sum_r[SW-2:0]);
    lim_s   = exp1_r - EW_ONE;
    shamt_s = {CW{1'b0}};
    if (sum_r[SW-1]) begin
      nsum_s = {1'b0, sum_r[SW-1:2], sum_r[1] | sum_r[0]};
      nexp_s = exp1_r + EW_ONE;
    end else begin
      if (CW'(lz_s) > CW'(lim_s)) shamt_s = CW'(lim_s);
      else shamt_s = CW'(lz_s);
      nsum_s = sum_r << shamt_s;
      nexp_s = exp1_r - EW'(shamt_s);
    end
  end

  // ROUND: apply rounding mode, resolve overflow, zero sign and special results
  logic [MAN_W:0]   mant_s, mant_f_s;
  logic [MAN_W+1:0] mant_inc_s;
  logic             g_s, r_s, st_s, inexact_s, inc_s, ovf_s, uf_s, zero_s, zsign_s, to_inf_s;
  logic [EW-1:0]    exp_f_s, exp_field_s;
  logic [W-1:0]     rres_s;
  logic [3:0]       rexc_s;
  always_comb begin
    mant_s    = sum_r[SW-2:3];
    g_s       = sum_r[2];
    r_s       = sum_r[1];
    st_s      = sum_r[0];
    inexact_s = g_s | r_s | st_s;
    case (rnd_r)
      2'd0:    inc_s = g_s & (r_s | st_s | sum_r[3]);
      2'd1:    inc_s = 1'b0;
      2'd2:    inc_s = inexact_s & ~sign1_r;
      2'd3:    inc_s = inexact_s & sign1_r;
      default: inc_s = 1'b0;
    endcase
    mant_inc_s = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, inc_s};
    if (mant_inc_s[MAN_W+1]) begin
      mant_f_s = mant_inc_s[MAN_W+1:1];
      exp_f_s  = exp1_r + EW_ONE;
    end else begin
      mant_f_s = mant_inc_s[MAN_W:0];
      exp_f_s  = exp1_r;
    end
    exp_field_s = mant_f_s[MAN_W] ? exp_f_s : {EW{1'b0}};
    ovf_s       = (exp_f_s >= EMAX);
    uf_s        = (exp_field_s == {EW{1'b0}}) && inexact_s;
    zero_s      = (mant_s == {(MAN_W+1){1'b0}}) && !inexact_s;
    zsign_s     = same_sign_r ? sign1_r : (rnd_r == 2'd3);
    case (rnd_r)
      2'd0:    to_inf_s = 1'b1;
      2'd1:    to_inf_s = 1'b0;
      2'd2:    to_inf_s = ~sign1_r;
      2'd3:    to_inf_s = sign1_r;
      default: to_inf_s = 1'b1;
    endcase
    if (spec_r) begin
      rres_s = spec_res_r;
      rexc_s = {spec_inv_r, 3'b000};
    end else if (ovf_s) begin
      rres_s = to_inf_s ? {sign1_r, E_ONES, F_ZERO}
                        : {sign1_r, E_ONES - {{(EXP_W-1){1'b0}}, 1'b1}, {MAN_W{1'b1}}};
      rexc_s = 4'b0101;
    end else if (zero_s) begin
      rres_s = {zsign_s, E_ZERO, F_ZERO};
      rexc_s = 4'b0000;
    end else begin
      rres_s = {sign1_r, exp_field_s[EXP_W-1:0], mant_f_s[MAN_W-1:0]};
      rexc_s = {1'b0, 1'b0, uf_s, inexact_s};
    end
  end

  // Control FSM and datapath registers with registered handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      mode_r      <= 1'b0;
      rnd_r       <= 2'b00;
      sign1_r     <= 1'b0;
      same_sign_r <= 1'b0;
      exp1_r      <= {EW{1'b0}};
      sig1_r      <= {SW{1'b0}};
      sig2_r      <= {SW{1'b0}};
      sum_r       <= {SW{1'b0}};
      spec_r      <= 1'b0;
      spec_inv_r  <= 1'b0;
      spec_res_r  <= {W{1'b0}};
      res_r       <= {W{1'b0}};
      exc_r       <= 4'b0000;
      dout_r      <= {W{1'b0}};
      exc_out_r   <= 4'b0000;
      dvalid_r    <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Data_valid && ready_r) begin
            a_r     <= Datain1;
            b_r     <= Datain2;
            mode_r  <= Mode;
            rnd_r   <= Rnd;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ALIGN;
          end
        end
        ALIGN: begin
          sign1_r     <= s1_s;
          same_sign_r <= (sa_s == sb_s);
          exp1_r      <= e1_s;
          sig1_r      <= sig1_s;
          sig2_r      <= sig2_s;
          spec_r      <= spec_s;
          spec_inv_r  <= spec_inv_s;
          spec_res_r  <= spec_res_s;
          state_r     <= ADD;
        end
        ADD: begin
          sum_r   <= same_sign_r ? (sig1_r + sig2_r) : (sig1_r - sig2_r);
          state_r <= NORM;
        end
        NORM: begin
          sum_r   <= nsum_s;
          exp1_r  <= nexp_s;
          state_r <= ROUND;
        end
        ROUND: begin
          res_r   <= rres_s;
          exc_r   <= rexc_s;
          state_r <= DONE;
        end
        DONE: begin
          if (!dvalid_r) begin
            dout_r    <= res_r;
            exc_out_r <= exc_r;
            dvalid_r  <= 1'b1;
          end else if (Dataout_ready) begin
            dvalid_r <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          dvalid_r <= 1'b0;
          ready_r  <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign Data_ready    = ready_r;
  assign Dataout       = dout_r;
  assign Exc           = exc_out_r;
  assign Dataout_valid = dvalid_r;
  assign Busy          = busy_r;

endmodule

// File: tb/tb_fp_addsub_rnd.sv
// Self-checking bench for fp_addsub_rnd: single-precision vector table with a
// result scoreboard, handshake/reset sequences, and a half-precision instance.
module tb_fp_addsub_rnd;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Datain1, Datain2, Dataout;
  logic        Mode, Data_valid, Data_ready, Dataout_valid, Dataout_ready, Busy;
  logic [1:0]  Rnd;
  logic [3:0]  Exc;

  logic [15:0] h_Datain1, h_Datain2, h_Dataout;
  logic        h_Mode, h_Data_valid, h_Data_ready, h_Dataout_valid, h_Dataout_ready, h_Busy;
  logic [1:0]  h_Rnd;
  logic [3:0]  h_Exc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic [1:0]  r;
    logic [31:0] eo;
    logic [3:0]  ee;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  e;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[30];

  fp_addsub_rnd dut (
    .CLK(CLK), .RST(RST), .Datain1(Datain1), .Datain2(Datain2), .Mode(Mode),
    .Rnd(Rnd), .Data_valid(Data_valid), .Data_ready(Data_ready), .Dataout(Dataout),
    .Exc(Exc), .Dataout_valid(Dataout_valid), .Dataout_ready(Dataout_ready), .Busy(Busy)
  );

  fp_addsub_rnd #(.EXP_W(5), .MAN_W(10)) dut_h (
    .CLK(CLK), .RST(RST), .Datain1(h_Datain1), .Datain2(h_Datain2), .Mode(h_Mode),
    .Rnd(h_Rnd), .Data_valid(h_Data_valid), .Data_ready(h_Data_ready), .Dataout(h_Dataout),
    .Exc(h_Exc), .Dataout_valid(h_Dataout_valid), .Dataout_ready(h_Dataout_ready), .Busy(h_Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Scoreboard: a result is consumed at the posedge following a negedge with valid & ready
  always @(negedge CLK) begin
    if (!RST && Dataout_valid && Dataout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", Dataout, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_data"}, Dataout, e.d);
        chk({e.nm, "_exc"}, {28'h0, Exc}, {28'h0, e.e});
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [1:0] r, input logic [31:0] eo, input logic [3:0] ee,
                        input string nm);
    int cyc;
    exp_t e;
    @(negedge CLK);
    Datain1 = a; Datain2 = b; Mode = m; Rnd = r; Data_valid = 1'b1;
    cyc = 0;
    while (!Data_ready && cyc < 20) begin @(negedge CLK); cyc++; end
    chk({nm, "_ready_wait"}, {31'h0, Data_ready}, 32'h1);
    @(posedge CLK);
    e.d = eo; e.e = ee; e.nm = nm;
    exp_q.push_back(e);
    #1;
    Data_valid = 1'b0;
    Datain1 = $urandom; Datain2 = $urandom; Mode = ~m; Rnd = ~r;
    chk({nm, "_busy"}, {31'h0, Busy}, 32'h1);
    cyc = 0;
    while (!Dataout_valid && cyc < 30) begin @(posedge CLK); #1; cyc++; end
    chk({nm, "_latency"}, cyc, 32'd5);
    @(posedge CLK); #1;
    chk({nm, "_valid_drop"}, {31'h0, Dataout_valid}, 32'h0);
  endtask

  task automatic run_h(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [1:0] r, input logic [15:0] eo, input logic [3:0] ee,
                       input string nm);
    int cyc;
    @(negedge CLK);
    h_Datain1 = a; h_Datain2 = b; h_Mode = m; h_Rnd = r; h_Data_valid = 1'b1;
    cyc = 0;
    while (!h_Data_ready && cyc < 20) begin @(negedge CLK); cyc++; end
    @(posedge CLK); #1;
    h_Data_valid = 1'b0;
    cyc = 0;
    while (!h_Dataout_valid && cyc < 30) begin @(posedge CLK); #1; cyc++; end
    chk({nm, "_latency"}, cyc, 32'd5);
    chk({nm, "_data"}, {16'h0, h_Dataout}, {16'h0, eo});
    chk({nm, "_exc"}, {28'h0, h_Exc}, {28'h0, ee});
    @(posedge CLK); #1;
  endtask

  // Watchdog against a hung handshake
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    nv = 0;
    vecs[nv++] = '{32'h3F800000, 32'h3F800000, 1'b0, 2'd0, 32'h40000000, 4'b0000};
    vecs[nv++] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd0, 32'h00000000, 4'b0000};
    vecs[nv++] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd3, 32'h80000000, 4'b0000};
    vecs[nv++] = '{32'h3F800000, 32'h33800000, 1'b0, 2'd0, 32'h3F800000, 4'b0001};
    vecs[nv++] = '{32'h3F800000, 32'h33800001, 1'b0, 2'd0, 32'h3F800001, 4'b0001};
    vecs[nv++] = '{32'h3F800001, 32'h33800000, 1'b0, 2'd0, 32'h3F800002, 4'b0001};
    vecs[nv++] = '{32'h3F800000, 32'h33800000, 1'b0, 2'd2, 32'h3F800001, 4'b0001};
    vecs[nv++] = '{32'h3F800000, 32'h33800000, 1'b0, 2'd3, 32'h3F800000, 4'b0001};
    vecs[nv++] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000, 4'b0101};
    vecs[nv++] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd1, 32'h7F7FFFFF, 4'b0101};
    vecs[nv++] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd3, 32'h7F7FFFFF, 4'b0101};
    vecs[nv++] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'd2, 32'hFF7FFFFF, 4'b0101};
    vecs[nv++] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'd3, 32'hFF800000, 4'b0101};
    vecs[nv++] = '{32'h7F800000, 32'hFF800000, 1'b0, 2'd0, 32'h7FC00000, 4'b1000};
    vecs[nv++] = '{32'h7FC00001, 32'h3F800000, 1'b0, 2'd0, 32'h7FC00000, 4'b1000};
    vecs[nv++] = '{32'h7F800000, 32'h3F800000, 1'b0, 2'd0, 32'h7F800000, 4'b0000};
    vecs[nv++] = '{32'h7F800000, 32'hFF800000, 1'b1, 2'd0, 32'h7F800000, 4'b0000};
    vecs[nv++] = '{32'h00000001, 32'h00000001, 1'b0, 2'd0, 32'h00000002, 4'b0000};
    vecs[nv++] = '{32'h00400000, 32'h00400000, 1'b0, 2'd0, 32'h00800000, 4'b0000};
    vecs[nv++] = '{32'h40400000, 32'h3F800000, 1'b1, 2'd0, 32'h40000000, 4'b0000};
    vecs[nv++] = '{32'h3F800001, 32'h3F800000, 1'b1, 2'd0, 32'h34000000, 4'b0000};
    vecs[nv++] = '{32'h3F800000, 32'h3FC00000, 1'b1, 2'd0, 32'hBF000000, 4'b0000};
    vecs[nv++] = '{32'hBF800000, 32'hBF800000, 1'b0, 2'd0, 32'hC0000000, 4'b0000};
    vecs[nv++] = '{32'h80000000, 32'h80000000, 1'b0, 2'd0, 32'h80000000, 4'b0000};
    vecs[nv++] = '{32'h3F800000, 32'h00000001, 1'b0, 2'd2, 32'h3F800001, 4'b0001};
    vecs[nv++] = '{32'h3F800000, 32'h00000001, 1'b0, 2'd0, 32'h3F800000, 4'b0001};

    RST = 1'b1;
    Datain1 = 32'h0; Datain2 = 32'h0; Mode = 1'b0; Rnd = 2'd0; Data_valid = 1'b0;
    Dataout_ready = 1'b1;
    h_Datain1 = 16'h0; h_Datain2 = 16'h0; h_Mode = 1'b0; h_Rnd = 2'd0;
    h_Data_valid = 1'b0; h_Dataout_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'h0, Data_ready}, 32'h1);
    chk("rst_valid", {31'h0, Dataout_valid}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_data", Dataout, 32'h0);
    chk("rst_exc", {28'h0, Exc}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < nv; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].eo, vecs[i].ee,
             $sformatf("vec%0d", i));
    end

    // Consumer stalls for 10 cycles: result and handshake state must hold
    begin
      int cyc;
      exp_t e;
      Dataout_ready = 1'b0;
      @(negedge CLK);
      Datain1 = 32'h40400000; Datain2 = 32'h3F800000; Mode = 1'b0; Rnd = 2'd0;
      Data_valid = 1'b1;
      @(posedge CLK);
      e.d = 32'h40800000; e.e = 4'b0000; e.nm = "hold";
      exp_q.push_back(e);
      #1 Data_valid = 1'b0;
      cyc = 0;
      while (!Dataout_valid && cyc < 30) begin @(posedge CLK); #1; cyc++; end
      chk("hold_latency", cyc, 32'd5);
      for (int k = 0; k < 10; k++) begin
        @(posedge CLK); #1;
        chk("hold_data", Dataout, 32'h40800000);
        chk("hold_valid", {31'h0, Dataout_valid}, 32'h1);
        chk("hold_dready", {31'h0, Data_ready}, 32'h0);
      end
      Dataout_ready = 1'b1;
      @(posedge CLK); #1;
      chk("hold_release_valid", {31'h0, Dataout_valid}, 32'h0);
      chk("hold_release_ready", {31'h0, Data_ready}, 32'h1);
      chk("hold_release_busy", {31'h0, Busy}, 32'h0);
      chk("hold_keep_data", Dataout, 32'h40800000);
    end

    // Reset while in ADD: in-flight operation is discarded
    begin
      @(negedge CLK);
      Datain1 = 32'h3F800000; Datain2 = 32'h3F800000; Mode = 1'b0; Rnd = 2'd0;
      Data_valid = 1'b1;
      @(posedge CLK);
      #1 Data_valid = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      #1;
      chk("midrst_valid", {31'h0, Dataout_valid}, 32'h0);
      chk("midrst_busy", {31'h0, Busy}, 32'h0);
      chk("midrst_ready", {31'h0, Data_ready}, 32'h1);
      chk("midrst_data", Dataout, 32'h0);
      chk("midrst_exc", {28'h0, Exc}, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge CLK); #1;
        chk("midrst_no_result", {31'h0, Dataout_valid}, 32'h0);
      end
      run_op(32'h40400000, 32'h3F800000, 1'b1, 2'd0, 32'h40000000, 4'b0000, "after_rst");
    end

    run_h(16'h3C00, 16'h3C00, 1'b0, 2'd0, 16'h4000, 4'b0000, "half_add");
    run_h(16'h3C00, 16'h3C00, 1'b1, 2'd0, 16'h0000, 4'b0000, "half_sub");
    run_h(16'h7BFF, 16'h7BFF, 1'b0, 2'd0, 16'h7C00, 4'b0101, "half_ovf_rne");
    run_h(16'h7BFF, 16'h7BFF, 1'b0, 2'd1, 16'h7BFF, 4'b0101, "half_ovf_rtz");

    repeat (3) @(posedge CLK);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
